rv32_inst_encoder: RTL and testbench
====================================

Name: rv32_inst_encoder

Overview:
- Inverse of the core's immediate generator. Packs opcode, register, funct and 32-bit immediate fields into an ISA-canonical RV32I instruction word.
- Range- and alignment-checks the immediate.
- Streams encoded words with an incrementing byte address toward the instruction-memory loader. Used by the self-test program builder and by the verification harness.
- Valid/ready on both sides, one registered output stage.

Parameters:
- BASE_ADDR, 32'h0000_0000, address loaded into the address counter at reset.
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept fields this cycle
- in_fmt  in  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal
- in_opcode  in  7  opcode field
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7; for shift-immediates, supplies bits [31:25]
- in_imm  in  32  signed byte immediate; for U format, the full upper value
- addr_load  in  1  load the address counter
- addr_value  in  32  value for addr_load
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts the word
- out_instr  out  32  encoded instruction
- out_addr  out  32  byte address of out_instr
- out_err  out  1  word was encoded with an immediate or format error
- err_count  out  ERR_CNT_W  saturating count of accepted erroneous words

Behaviour:
- Reset (async, rst=1): out_valid=0, out_instr=0, out_err=0, err_count=0, address counter=BASE_ADDR, out_addr=BASE_ADDR.
- Handshakes:
  - in_ready = !out_valid || out_ready.
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
- Latency: exactly 1 cycle. Fields accepted at edge N appear on out_* after edge N, held stable until consumed. Full throughput of one word per cycle when out_ready stays high.
- Address counter:
  - On accept: out_addr <= counter; counter <= counter + 4 (wraps modulo 2^32).
  - addr_load sets counter <= addr_value.
  - addr_load in the same cycle as an accept: the accepted word takes addr_value, and the counter becomes addr_value + 4.
- Encoding (fixed fields: opcode→[6:0], rd→[11:7], funct3→[14:12], rs1→[19:15], rs2→[24:20]):
  - R: funct7→[31:25].
  - I: imm[11:0]→[31:20]; rs2 field unused.
  - I-shift (opcode 0010011, funct3 001/101): {funct7, imm[4:0]}→[31:20].
  - S: imm[11:5]→[31:25], imm[4:0]→[11:7].
  - B: imm[12]→31, imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→7.
  - U: imm[31:12]→[31:12].
  - J: imm[20]→31, imm[10:1]→[30:21], imm[11]→20, imm[19:12]→[19:12].
- Error checks (combinational on input, registered into out_err):
  - I and S: imm must lie in [-2048, 2047].
  - I-shift: imm[31:5] must be 0.
  - B: imm must lie in [-4096, 4094] and imm[0] must be 0.
  - J: imm must lie in [-2^20, 2^20-2] and imm[0] must be 0.
  - U: imm[11:0] must be 0.
  - Illegal fmt: out_instr = 32'h0000_0013 (NOP), out_err = 1.
  - Range/alignment error: the word is still emitted with bits truncated per the encoding, and out_err = 1.
- err_count increments on each accept whose error flag is set; saturates at all-ones.
- Reset mid-stream: a pending word is discarded and never re-emitted.
- Round-trip invariant: the ISA-spec immediate decode of out_instr equals in_imm for every error-free I/S/B/U/J word.

Decomposition:
- Shared defines package: format codes (FMT_R…FMT_J), opcode constants (shared with the existing OPCODE_* defines), NOP constant 32'h0000_0013.
- One natural sub-module, rv32_imm_range_chk: combinational, in_fmt/in_imm/shift flag → error bit.

Test Plan:
- ADDI: fmt=I, op=0010011, rd=1, rs1=0, f3=0, imm=5 → out_instr=0x00500093, out_addr=BASE_ADDR, out_err=0.
- SW: fmt=S, op=0100011, f3=010, rs1=1, rs2=2, imm=8 → 0x0020A423. Next BEQ x0,x0 with imm=-4 → 0xFE000EE3, out_addr=BASE+4.
- JAL: fmt=J, op=1101111, rd=1, imm=0x800 → 0x001000EF. LUI: fmt=U, op=0110111, rd=5, imm=0x12345000 → 0x123452B7.
- Errors: B imm=3 → out_err=1, err_count=1. I imm=2048 → err_count=2. fmt=7 → out_instr=0x00000013, err_count=3. err_count preset near saturation stays at all-ones.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → out_instr/out_addr stable, in_ready=0, counter unchanged. Release → next word has the next address. addr_load=0x100 with an accept → that word at 0x100, following word at 0x104.
- Assert rst while out_valid=1 and out_ready=0 → out_valid=0 immediately, counter=BASE_ADDR, and the discarded word never appears.

Source files
------------

// File: rtl/rv32_inst_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: format codes,
// base opcodes and the canonical NOP word.
package rv32_inst_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // SLLI/SRLI/SRAI carry a 5-bit shamt and take bits [31:25] from funct7.
  function automatic logic is_shift_imm(input logic [2:0] fmt,
                                        input logic [6:0] opcode,
                                        input logic [2:0] funct3);
    return (fmt == FMT_I) && (opcode == OPCODE_OP_IMM) &&
           ((funct3 == 3'b001) || (funct3 == 3'b101));
  endfunction

endpackage

// File: rtl/rv32_imm_range_chk.sv
// Combinational range/alignment check of an immediate against the field
// width its instruction format can represent.
module rv32_imm_range_chk
  import rv32_inst_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  input  logic        shift,
  output logic        err
);

  // A signed value fits in N bits when bits [31:N-1] are all copies of the sign.
  logic fits12;
  logic fits13;
  logic fits21;

  assign fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign fits21 = (imm[31:20] == '0) || (imm[31:20] == '1);

  // Select the check that matches the format; unknown formats are always errors.
  always_comb begin
    err = 1'b0;
    case (fmt)
      FMT_R:   err = 1'b0;
      FMT_I:   err = shift ? (imm[31:5] != '0) : !fits12;
      FMT_S:   err = !fits12;
      FMT_B:   err = imm[0] || !fits13;
      FMT_U:   err = (imm[11:0] != '0);
      FMT_J:   err = imm[0] || !fits21;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32_inst_encoder.sv
// Packs RV32I fields into instruction words and streams them, one registered
// stage deep, with an incrementing byte address toward the imem loader.
module rv32_inst_encoder
  import rv32_inst_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_fmt,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [31:0]          in_imm,
  input  logic                 addr_load,
  input  logic [31:0]          addr_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [31:0]          out_addr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic        accept;
  logic        shift;
  logic        imm_err;
  logic        enc_err;
  logic [31:0] enc_instr;
  logic [31:0] addr_cnt;
  logic [31:0] word_addr;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign shift     = is_shift_imm(in_fmt, in_opcode, in_funct3);
  // A same-cycle load takes effect for the word being accepted.
  assign word_addr = addr_load ? addr_value : addr_cnt;

  rv32_imm_range_chk u_range_chk (
    .fmt   (in_fmt),
    .imm   (in_imm),
    .shift (shift),
    .err   (imm_err)
  );

  assign enc_err = imm_err;

  // Scatter the immediate into the format's bit positions; out-of-range
  // immediates are simply truncated here and flagged separately.
  always_comb begin
    enc_instr = NOP_INSTR;
    case (in_fmt)
      FMT_R: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: enc_instr = shift ?
                         {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode} :
                         {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S: enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      FMT_B: enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], in_opcode};
      FMT_U: enc_instr = {in_imm[31:12], in_rd, in_opcode};
      FMT_J: enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                          in_rd, in_opcode};
      default: enc_instr = NOP_INSTR;
    endcase
  end

  // Output stage: load on accept, drop valid once the consumer takes the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      out_addr  <= BASE_ADDR;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_instr <= enc_instr;
      out_err   <= enc_err;
      out_addr  <= word_addr;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Address counter advances by one word per accept; addr_load retargets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt <= BASE_ADDR;
    end else if (accept) begin
      addr_cnt <= word_addr + 32'd4;
    end else if (addr_load) begin
      addr_cnt <= addr_value;
    end
  end

  // Saturating count of accepted words that carried an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (accept && enc_err && (err_count != '1)) begin
      err_count <= err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_rv32_inst_encoder.sv
// Directed scoreboard bench for rv32_inst_encoder.
module tb_rv32_inst_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          ECW  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     in_fmt;
  logic [6:0]     in_opcode;
  logic [4:0]     in_rd;
  logic [4:0]     in_rs1;
  logic [4:0]     in_rs2;
  logic [2:0]     in_funct3;
  logic [6:0]     in_funct7;
  logic [31:0]    in_imm;
  logic           addr_load;
  logic [31:0]    addr_value;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    out_instr;
  logic [31:0]    out_addr;
  logic           out_err;
  logic [ECW-1:0] err_count;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl_cnt;
  int          n_assert = 0;
  int          n_fail   = 0;

  rv32_inst_encoder #(.BASE_ADDR(BASE), .ERR_CNT_W(ECW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .addr_load  (addr_load),
    .addr_value (addr_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .out_err    (out_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard sink: every consumed word must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      check("sb_has_entry", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_instr", out_instr, e.instr);
        check("out_addr", out_addr, e.addr);
        check("out_err", {31'b0, out_err}, {31'b0, e.err});
      end
    end
  end

  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input logic load, input logic [31:0] lval,
                      input logic [31:0] exp_instr, input logic exp_err);
    logic        done;
    logic [31:0] a;
    exp_t        e;
    done = 1'b0;
    drive(fmt, op, rd, rs1, rs2, f3, f7, imm);
    addr_load  = load;
    addr_value = lval;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        a = load ? lval : mdl_cnt;
        e.instr = exp_instr; e.addr = a; e.err = exp_err;
        sb.push_back(e);
        mdl_cnt = a + 32'd4;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        addr_load = 1'b0;
        done = 1'b1;
      end
    end
    check("accepted", {31'b0, done}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drained", sb.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; addr_load = 1'b0; addr_value = '0;
    drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b0;
    mdl_cnt = BASE;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", {31'b0, out_err}, 32'd0);
    check("rst_err_count", {30'b0, err_count}, 32'd0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Canonical encodings, back to back at full throughput.
    send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 1'b0, 0, 32'h0050_0093, 1'b0);
    send(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 1'b0, 0, 32'h0020_A423, 1'b0);
    send(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd4, 1'b0, 0, 32'hFE00_0EE3, 1'b0);
    send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h800, 1'b0, 0, 32'h0010_00EF, 1'b0);
    send(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5000, 1'b0, 0, 32'h1234_52B7, 1'b0);
    send(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b101, 7'b0100000, 32'd3, 1'b0, 0, 32'h4031_5093, 1'b0);
    check("err_count_clean", {30'b0, err_count}, 32'd0);

    // Error words: still emitted (truncated or NOP), counter saturates at 3.
    send(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3, 1'b0, 0, 32'h0000_0163, 1'b1);
    check("err_count_1", {30'b0, err_count}, 32'd1);
    send(3'd1, 7'b0010011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 1'b0, 0, 32'h8000_0013, 1'b1);
    check("err_count_2", {30'b0, err_count}, 32'd2);
    send(3'd7, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 1'b0, 0, 32'h0000_0013, 1'b1);
    check("err_count_3", {30'b0, err_count}, 32'd3);
    send(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5001, 1'b0, 0, 32'h1234_52B7, 1'b1);
    check("err_count_sat", {30'b0, err_count}, 32'd3);
    drain();

    // Backpressure: word A held while B waits with in_valid high.
    out_ready = 1'b0;
    send(3'd1, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF, 1'b0, 0, 32'hFFF0_0193, 1'b0);
    drive(3'd0, 7'b0110011, 5'd4, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check("stall_out_instr", out_instr, 32'hFFF0_0193);
      check("stall_out_addr", out_addr, BASE + 32'h28);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3'd0, 7'b0110011, 5'd4, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 1'b0, 0, 32'h0020_8233, 1'b0);

    // Address reload coinciding with an accept.
    send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 1'b1, 32'h100, 32'h0050_0093, 1'b0);
    send(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 1'b0, 0, 32'h0020_A423, 1'b0);
    drain();

    // Reset with a word pending: it must vanish for good.
    out_ready = 1'b0;
    send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h800, 1'b0, 0, 32'h0010_00EF, 1'b0);
    check("pend_out_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_out_addr", out_addr, BASE);
    check("mid_rst_err_count", {30'b0, err_count}, 32'd0);
    sb.delete();
    mdl_cnt = BASE;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5000, 1'b0, 0, 32'h1234_52B7, 1'b0);
    drain();
    repeat (5) @(posedge clk);
    check("idle_out_valid", {31'b0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
